alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Controller that shares the single 64-bit execute-stage ALU (ADD/SUB/AND/XOR units) between two requesters.
  - Requester 0: execute-stage OPq path.
  - Requester 1: address/stack-pointer generation.
- Round-robin arbitration over the two requesters.
- Registers the operands, drives the combinational ALU, and captures the result and overflow flag.
- Returns the result through a valid/ready response channel and owns the condition-code register (ZF, SF, OF).

Parameters:
- WIDTH, 64, datapath width in bits; all arithmetic is two's complement.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid; bit i belongs to requester i
- req_ready  out  2  per-requester accept strobe
- req_fn  in  4  {fn1, fn0}, 2 bits each: 0 ADD, 1 SUB, 2 AND, 3 XOR
- req_a  in  2*WIDTH  {a1, a0}, valA operands
- req_b  in  2*WIDTH  {b1, b0}, valB operands
- req0_set_cc  in  1  requester 0 asks for a CC update on this op
- alu_fn  out  2  function select to the shared ALU
- alu_a  out  WIDTH  operand A to the ALU
- alu_b  out  WIDTH  operand B to the ALU
- alu_y  in  WIDTH  ALU result: ADD b+a, SUB b-a, AND b&a, XOR b^a
- alu_of  in  1  ALU signed-overflow flag
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  index of the requester that owns rsp_y
- rsp_y  out  WIDTH  captured result
- zf, sf, of  out  1 each  condition-code register
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately on rst=1):
  - state=IDLE, rr_last=1 (so requester 0 wins first).
  - alu_fn/alu_a/alu_b=0; rsp_valid=0, rsp_id=0, rsp_y=0.
  - zf=1, sf=0, of=0 (the y86 initial CC).
  - busy=0, req_ready=0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - req_ready is combinational; nonzero only in IDLE, and at most one bit set.
  - Grant goes to the single valid requester. If both are valid, grant goes to ~rr_last.
  - On the accepting edge: latch fn, a, b, id and set_cc (forced to 0 when id=1) into the alu_* and internal registers; rr_last<=id; go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_* are held stable from registers.
  - At the end-of-cycle edge: rsp_y<=alu_y, rsp_id<=id, rsp_valid<=1; go to RESP.
  - If the latched set_cc=1, update CC on the same edge:
    - zf<=(alu_y==0)
    - sf<=alu_y[WIDTH-1]
    - of<=alu_of when fn is ADD or SUB, else 0 (AND/XOR always clear OF regardless of alu_of).
- RESP:
  - rsp_valid=1; rsp_y and rsp_id are held until rsp_ready=1.
  - On the edge where rsp_valid&rsp_ready: rsp_valid<=0, go to IDLE.
  - No new grant happens in RESP; new requests wait.
- Timing:
  - Latency is 2 cycles from the accept edge to the first cycle of rsp_valid=1.
  - Peak throughput is 1 op per 3 cycles, with rsp_ready held high.
- Requester rules:
  - A requester must hold valid and payload until its req_ready bit is seen.
  - Dropping valid before grant is legal; the request is simply not served.
- CC behaviour:
  - CC changes only on EXEC edges of requester-0 ops with set_cc=1.
  - Requester-1 ops never touch CC.
- Outputs are registered except req_ready and busy.
- Reset mid-operation (EXEC or RESP): the op is discarded, no response is produced, and CC returns to reset values.
- Back-pressure: rsp_ready held low keeps the FSM in RESP indefinitely, and both req_ready bits stay 0.
- Simultaneous request and reset: reset wins; nothing is accepted.
- Arithmetic wrap and overflow detection belong to the ALU. The controller never recomputes them; it only gates OF by function.

Test Plan:
- XOR, requester 0, set_cc=1: a=0x7FFFFFFFFFFFFFFF, b=0x8000000000000000 -> rsp_y=0xFFFFFFFFFFFFFFFF, rsp_id=0, zf=0, sf=1, of=0, rsp_valid exactly 2 cycles after accept.
- XOR, requester 0, set_cc=1: a=b=0x8000000000000000 -> rsp_y=0, zf=1, sf=0, of=0. Repeat with set_cc=0 after a nonzero op -> CC unchanged.
- ADD, requester 0, set_cc=1, bench reference ALU: a=1, b=0x7FFFFFFFFFFFFFFF -> rsp_y=0x8000000000000000, sf=1, of=1. Follow with AND a=b=1 -> of=0.
- Both req_valid held high from reset, rsp_ready=1, 4 ops -> grants ordered 0,1,0,1, one accept every 3 cycles. Requester-1 SUB (a=1, b=0 -> rsp_y=-1) leaves CC untouched.
- rsp_ready=0 for 5 cycles during RESP -> rsp_y and rsp_id stable, busy=1, req_ready=00. Release -> IDLE next cycle.
- Assert rst during EXEC -> immediate IDLE, rsp_valid=0, zf=1, sf=0, of=0. After deassert, the pending requester is re-granted and served normally.

Source files
------------

// File: rtl/alu_share_ctrl_if.sv
// rtl/alu_share_ctrl_if.sv - request, response, shared-ALU and condition-code bundle
interface alu_share_ctrl_if #(
   parameter int WIDTH = 64
);
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [3:0]         req_fn;
   logic [2*WIDTH-1:0] req_a;
   logic [2*WIDTH-1:0] req_b;
   logic               req0_set_cc;
   logic [1:0]         alu_fn;
   logic [WIDTH-1:0]   alu_a;
   logic [WIDTH-1:0]   alu_b;
   logic [WIDTH-1:0]   alu_y;
   logic               alu_of;
   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_id;
   logic [WIDTH-1:0]   rsp_y;
   logic               zf;
   logic               sf;
   logic               of;
   logic               busy;

   modport slave (
      input  req_valid, req_fn, req_a, req_b, req0_set_cc, alu_y, alu_of, rsp_ready,
      output req_ready, alu_fn, alu_a, alu_b, rsp_valid, rsp_id, rsp_y, zf, sf, of, busy
   );

   modport master (
      output req_valid, req_fn, req_a, req_b, req0_set_cc, alu_y, alu_of, rsp_ready,
      input  req_ready, alu_fn, alu_a, alu_b, rsp_valid, rsp_id, rsp_y, zf, sf, of, busy
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin sharing of one ALU between two requesters
module alu_share_ctrl #(
   parameter int WIDTH = 64
) (
   input logic            clk,
   input logic            rst,
   alu_share_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [1:0] FN_ADD = 2'd0;
   localparam logic [1:0] FN_SUB = 2'd1;

   state_t             state_q, state_d;
   logic               rr_last_q, rr_last_d;
   logic [1:0]         fn_q, fn_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               id_q, id_d;
   logic               set_cc_q, set_cc_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]   rsp_y_q, rsp_y_d;
   logic               zf_q, zf_d;
   logic               sf_q, sf_d;
   logic               of_q, of_d;
   logic [1:0]         req_ready_c;
   logic               grant_id;

   always_comb begin
      state_d     = state_q;
      rr_last_d   = rr_last_q;
      fn_d        = fn_q;
      a_d         = a_q;
      b_d         = b_q;
      id_d        = id_q;
      set_cc_d    = set_cc_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_y_d     = rsp_y_q;
      zf_d        = zf_q;
      sf_d        = sf_q;
      of_d        = of_q;
      req_ready_c = 2'b00;
      grant_id    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.req_valid != 2'b00) begin
               // With both valid, the requester not served last time wins.
               grant_id    = (bus.req_valid == 2'b11) ? ~rr_last_q : bus.req_valid[1];
               req_ready_c = grant_id ? 2'b10 : 2'b01;
               fn_d        = grant_id ? bus.req_fn[3:2] : bus.req_fn[1:0];
               a_d         = grant_id ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
               b_d         = grant_id ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
               id_d        = grant_id;
               set_cc_d    = ~grant_id & bus.req0_set_cc;
               rr_last_d   = grant_id;
               state_d     = EXEC;
            end
         end
         EXEC: begin
            rsp_y_d     = bus.alu_y;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            if (set_cc_q) begin
               zf_d = (bus.alu_y == '0);
               sf_d = bus.alu_y[WIDTH-1];
               // Logical ops always clear OF whatever the ALU reports.
               of_d = ((fn_q == FN_ADD) || (fn_q == FN_SUB)) ? bus.alu_of : 1'b0;
            end
            state_d = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_last_q   <= 1'b1;
         fn_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         id_q        <= 1'b0;
         set_cc_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_y_q     <= '0;
         zf_q        <= 1'b1;
         sf_q        <= 1'b0;
         of_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_last_q   <= rr_last_d;
         fn_q        <= fn_d;
         a_q         <= a_d;
         b_q         <= b_d;
         id_q        <= id_d;
         set_cc_q    <= set_cc_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_y_q     <= rsp_y_d;
         zf_q        <= zf_d;
         sf_q        <= sf_d;
         of_q        <= of_d;
      end
   end

   // Reset masks the grant so a request coinciding with reset is never accepted.
   assign bus.req_ready = rst ? 2'b00 : req_ready_c;
   assign bus.busy      = (state_q != IDLE);
   assign bus.alu_fn    = fn_q;
   assign bus.alu_a     = a_q;
   assign bus.alu_b     = b_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_y     = rsp_y_q;
   assign bus.zf        = zf_q;
   assign bus.sf        = sf_q;
   assign bus.of        = of_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - directed bench for alu_share_ctrl with a reference ALU
module tb_alu_share_ctrl;
   localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;
   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;

   alu_share_ctrl_if #(.WIDTH(64)) bus ();

   alu_share_ctrl #(.WIDTH(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Reference ALU; logical ops report OF=1 so that the controller's gating is exercised.
   always_comb begin
      case (bus.alu_fn)
         2'd0: bus.alu_y = bus.alu_b + bus.alu_a;
         2'd1: bus.alu_y = bus.alu_b - bus.alu_a;
         2'd2: bus.alu_y = bus.alu_b & bus.alu_a;
         default: bus.alu_y = bus.alu_b ^ bus.alu_a;
      endcase
      case (bus.alu_fn)
         2'd0: bus.alu_of = (bus.alu_a[63] == bus.alu_b[63]) && (bus.alu_y[63] != bus.alu_b[63]);
         2'd1: bus.alu_of = (bus.alu_a[63] != bus.alu_b[63]) && (bus.alu_y[63] != bus.alu_b[63]);
         default: bus.alu_of = 1'b1;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_cc(input string tag, input logic ezf, input logic esf, input logic eof);
      chk({tag, ".zf"}, 64'(bus.zf), 64'(ezf));
      chk({tag, ".sf"}, 64'(bus.sf), 64'(esf));
      chk({tag, ".of"}, 64'(bus.of), 64'(eof));
   endtask

   // Called #1 after a negedge with the DUT idle; returns #1 after a negedge, idle again.
   task automatic do_op(input string tag, input logic id, input logic [1:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic cc,
                        input logic [63:0] ey, input logic ezf, input logic esf, input logic eof);
      if (id) begin
         bus.req_fn[3:2]    = fn;
         bus.req_a[127:64]  = a;
         bus.req_b[127:64]  = b;
         bus.req_valid      = 2'b10;
      end else begin
         bus.req_fn[1:0]    = fn;
         bus.req_a[63:0]    = a;
         bus.req_b[63:0]    = b;
         bus.req0_set_cc    = cc;
         bus.req_valid      = 2'b01;
      end
      bus.rsp_ready = 1'b1;
      #1 chk({tag, ".ready"}, 64'(bus.req_ready), id ? 64'd2 : 64'd1);
      @(negedge clk);
      bus.req_valid = 2'b00;
      #1;
      chk({tag, ".exec_valid"}, 64'(bus.rsp_valid), 64'd0);
      chk({tag, ".exec_busy"}, 64'(bus.busy), 64'd1);
      chk({tag, ".alu_fn"}, 64'(bus.alu_fn), 64'(fn));
      @(negedge clk);
      #1;
      chk({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
      chk({tag, ".rsp_y"}, bus.rsp_y, ey);
      chk({tag, ".rsp_id"}, 64'(bus.rsp_id), 64'(id));
      chk_cc(tag, ezf, esf, eof);
      @(negedge clk);
      #1;
      chk({tag, ".idle_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, ".idle_valid"}, 64'(bus.rsp_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.req_valid   = 2'b00;
      bus.req_fn      = 4'd0;
      bus.req_a       = '0;
      bus.req_b       = '0;
      bus.req0_set_cc = 1'b0;
      bus.rsp_ready   = 1'b0;

      // Reset values
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst.busy", 64'(bus.busy), 64'd0);
      chk("rst.ready", 64'(bus.req_ready), 64'd0);
      chk("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst.rsp_id", 64'(bus.rsp_id), 64'd0);
      chk("rst.rsp_y", bus.rsp_y, 64'd0);
      chk("rst.alu_fn", 64'(bus.alu_fn), 64'd0);
      chk("rst.alu_a", bus.alu_a, 64'd0);
      chk("rst.alu_b", bus.alu_b, 64'd0);
      chk_cc("rst", 1'b1, 1'b0, 1'b0);

      // Requests during reset are never accepted; req0 ADD 3+2 set_cc, req1 SUB 0-1
      bus.req_fn      = 4'b0100;
      bus.req_a       = {64'd1, 64'd2};
      bus.req_b       = {64'd0, 64'd3};
      bus.req0_set_cc = 1'b1;
      bus.req_valid   = 2'b11;
      bus.rsp_ready   = 1'b1;
      #1 chk("rst_req.ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk);
      #1 chk("rst_req.busy", 64'(bus.busy), 64'd0);
      rst = 1'b0;

      // Both valid from reset: grants 0,1,0,1 every third cycle
      for (int t = 0; t < 12; t++) begin
         #1;
         if (t % 3 == 0) begin
            chk($sformatf("rr%0d.ready", t), 64'(bus.req_ready), ((t / 3) % 2 == 0) ? 64'd1 : 64'd2);
         end else if (t % 3 == 1) begin
            chk($sformatf("rr%0d.ready", t), 64'(bus.req_ready), 64'd0);
            chk($sformatf("rr%0d.busy", t), 64'(bus.busy), 64'd1);
            chk($sformatf("rr%0d.alu_fn", t), 64'(bus.alu_fn), ((t / 3) % 2 == 0) ? 64'd0 : 64'd1);
         end else begin
            chk($sformatf("rr%0d.rsp_valid", t), 64'(bus.rsp_valid), 64'd1);
            chk($sformatf("rr%0d.rsp_id", t), 64'(bus.rsp_id), ((t / 3) % 2 == 0) ? 64'd0 : 64'd1);
            chk($sformatf("rr%0d.rsp_y", t), bus.rsp_y, ((t / 3) % 2 == 0) ? 64'd5 : ONES);
            chk_cc($sformatf("rr%0d", t), 1'b0, 1'b0, 1'b0);
         end
         @(negedge clk);
      end
      bus.req_valid = 2'b00;
      #1;

      do_op("xor_sign", 1'b0, 2'd3, MAXP, MINN, 1'b1, ONES, 1'b0, 1'b1, 1'b0);
      do_op("xor_zero", 1'b0, 2'd3, MINN, MINN, 1'b1, 64'd0, 1'b1, 1'b0, 1'b0);
      do_op("xor_one", 1'b0, 2'd3, 64'd1, 64'd0, 1'b1, 64'd1, 1'b0, 1'b0, 1'b0);
      do_op("xor_nocc", 1'b0, 2'd3, MINN, MINN, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
      do_op("add_ovf", 1'b0, 2'd0, 64'd1, MAXP, 1'b1, MINN, 1'b0, 1'b1, 1'b1);
      do_op("and_clr", 1'b0, 2'd2, 64'd1, 64'd1, 1'b1, 64'd1, 1'b0, 1'b0, 1'b0);
      do_op("add_ovf2", 1'b0, 2'd0, 64'd1, MAXP, 1'b1, MINN, 1'b0, 1'b1, 1'b1);
      do_op("r1_sub", 1'b1, 2'd1, 64'd1, 64'd0, 1'b0, ONES, 1'b0, 1'b1, 1'b1);

      // Back-pressure: req1 XOR held in RESP while req0 ADD 5+5 waits
      bus.req_fn         = {2'd3, 2'd0};
      bus.req_a          = {64'hF0, 64'd5};
      bus.req_b          = {64'hFF, 64'd5};
      bus.req0_set_cc    = 1'b1;
      bus.req_valid      = 2'b10;
      bus.rsp_ready      = 1'b0;
      #1 chk("bp.ready", 64'(bus.req_ready), 64'd2);
      @(negedge clk);
      bus.req_valid = 2'b01;
      #1;
      chk("bp.exec_ready", 64'(bus.req_ready), 64'd0);
      chk("bp.exec_busy", 64'(bus.busy), 64'd1);
      @(negedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d.rsp_valid", i), 64'(bus.rsp_valid), 64'd1);
         chk($sformatf("bp%0d.rsp_y", i), bus.rsp_y, 64'h0F);
         chk($sformatf("bp%0d.rsp_id", i), 64'(bus.rsp_id), 64'd1);
         chk($sformatf("bp%0d.busy", i), 64'(bus.busy), 64'd1);
         chk($sformatf("bp%0d.ready", i), 64'(bus.req_ready), 64'd0);
         @(negedge clk);
         #1;
      end
      chk_cc("bp", 1'b0, 1'b1, 1'b1);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_rel.busy", 64'(bus.busy), 64'd0);
      chk("bp_rel.ready", 64'(bus.req_ready), 64'd1);

      // Reset during EXEC of the waiting req0 op, then re-grant
      @(negedge clk);
      #1 chk("mid.exec_busy", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid.busy", 64'(bus.busy), 64'd0);
      chk("mid.rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("mid.ready", 64'(bus.req_ready), 64'd0);
      chk("mid.alu_a", bus.alu_a, 64'd0);
      chk_cc("mid", 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("regrant.ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      bus.req_valid = 2'b00;
      #1 chk("regrant.busy", 64'(bus.busy), 64'd1);
      @(negedge clk);
      #1;
      chk("regrant.rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("regrant.rsp_y", bus.rsp_y, 64'd10);
      chk("regrant.rsp_id", 64'(bus.rsp_id), 64'd0);
      chk_cc("regrant", 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #1 chk("regrant.idle", 64'(bus.busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
